// File: rtl/gpu2_mm_pkg.sv
// Shared sizing constants, state encoding and helpers for the matrix operand feeder.
package gpu2_mm_pkg;

    localparam int DATA_W     = 32;
    localparam int N          = 4;
    localparam int LOAD_WORDS = N * N + N;

    // IDLE | ready for word 0;  LOAD | collecting words;  ISSUE | one valid pair
    // GAP_WAIT | idle spacing;  WAIT_DONE | waiting on multiplier;  DONE | frame_done pulse
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        GAP_WAIT,
        WAIT_DONE,
        DONE
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_regfile.sv
// Operand storage: one synchronous write port, two combinational read ports, no reset.
module operand_regfile #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 20,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [AW-1:0]     rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data
);
    import gpu2_mm_pkg::*;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_a_data = mem[rd_a_addr];
    assign rd_b_data = mem[rd_b_addr];

endmodule

// File: rtl/matrix_operand_feeder.sv
// Loads an NxN matrix plus an N-vector, then streams (M[r][c], V[c]) pairs
// to a multiplier with GAP idle cycles between valid cycles.
module matrix_operand_feeder #(
    parameter int DATA_W = gpu2_mm_pkg::DATA_W,
    parameter int N      = gpu2_mm_pkg::N,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              a_tvalid,
    output logic              b_tvalid,
    input  logic              done_matrixmult,
    output logic              busy,
    output logic              frame_done
);
    import gpu2_mm_pkg::*;

    localparam int LOAD_WORDS = N * N + N;
    localparam int PAIRS      = N * N;
    localparam int AW         = cnt_w(LOAD_WORDS);
    localparam int PW         = cnt_w(PAIRS);
    localparam logic [AW-1:0] LOAD_LAST = AW'(LOAD_WORDS - 1);
    localparam logic [PW-1:0] PAIR_LAST = PW'(PAIRS - 1);
    localparam logic [3:0]    GAP_INIT  = 4'((GAP > 0) ? GAP - 1 : 0);

    state_t            state, state_nx;
    logic [AW-1:0]     load_cnt, load_cnt_nx;
    logic [PW-1:0]     pair_cnt, pair_cnt_nx;
    logic [3:0]        gap_cnt, gap_cnt_nx;
    logic              issued, issued_nx;
    logic              started;
    logic              xfer;
    logic [AW-1:0]     rd_a_addr, rd_b_addr;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic [AW-1:0]     load_inc;
    logic [PW-1:0]     pair_inc;

    // started keeps load_ready low until the first edge after reset release
    assign load_ready = started && ((state == IDLE) || (state == LOAD));
    assign xfer       = load_ready && load_valid;
    assign load_inc   = (load_cnt == LOAD_LAST) ? load_cnt : load_cnt + 1'b1;
    assign pair_inc   = (pair_cnt == PAIR_LAST) ? pair_cnt : pair_cnt + 1'b1;

    assign rd_a_addr = AW'(pair_cnt);
    assign rd_b_addr = AW'(PAIRS + int'(pair_cnt) % N);

    operand_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (LOAD_WORDS),
        .AW     (AW)
    ) u_regfile (
        .clk       (clk),
        .we        (xfer),
        .wr_addr   (load_cnt),
        .wr_data   (load_data),
        .rd_a_addr (rd_a_addr),
        .rd_a_data (rd_a),
        .rd_b_addr (rd_b_addr),
        .rd_b_data (rd_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            load_cnt <= '0;
            pair_cnt <= '0;
            gap_cnt  <= '0;
            issued   <= 1'b0;
            started  <= 1'b0;
        end else begin
            state    <= state_nx;
            load_cnt <= load_cnt_nx;
            pair_cnt <= pair_cnt_nx;
            gap_cnt  <= gap_cnt_nx;
            issued   <= issued_nx;
            started  <= 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        load_cnt_nx = load_cnt;
        pair_cnt_nx = pair_cnt;
        gap_cnt_nx  = gap_cnt;
        issued_nx   = issued;
        if (clear) begin
            state_nx    = IDLE;
            load_cnt_nx = '0;
            pair_cnt_nx = '0;
            gap_cnt_nx  = '0;
            issued_nx   = 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (xfer) begin
                        load_cnt_nx = load_inc;
                        if (load_cnt == LOAD_LAST) begin
                            state_nx    = ISSUE;
                            pair_cnt_nx = '0;
                            issued_nx   = 1'b1;
                        end else begin
                            state_nx = LOAD;
                        end
                    end
                end
                ISSUE: begin
                    if (GAP > 0) begin
                        state_nx   = GAP_WAIT;
                        gap_cnt_nx = GAP_INIT;
                    end else if (pair_cnt == PAIR_LAST) begin
                        state_nx = WAIT_DONE;
                    end else begin
                        pair_cnt_nx = pair_inc;
                    end
                end
                GAP_WAIT: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt_nx = gap_cnt - 4'd1;
                    end else if (pair_cnt == PAIR_LAST) begin
                        state_nx = WAIT_DONE;
                    end else begin
                        state_nx    = ISSUE;
                        pair_cnt_nx = pair_inc;
                    end
                end
                WAIT_DONE: begin
                    if (done_matrixmult) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    state_nx    = IDLE;
                    load_cnt_nx = '0;
                    pair_cnt_nx = '0;
                    issued_nx   = 1'b0;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // operands read straight from storage; they only move when pair_cnt advances
    assign a          = issued ? rd_a : '0;
    assign b          = issued ? rd_b : '0;
    assign a_tvalid   = (state == ISSUE);
    assign b_tvalid   = (state == ISSUE);
    assign busy       = (state == LOAD) || (state == ISSUE) ||
                        (state == GAP_WAIT) || (state == WAIT_DONE);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_matrix_operand_feeder.sv
// Directed bench: one feeder with GAP=1 and one with GAP=0 fed from a shared load stream.
module tb_matrix_operand_feeder;

    localparam int DW = 32;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          clear      = 1'b0;
    logic [DW-1:0] load_data  = '0;
    logic          load_valid = 1'b0;
    logic          done_g1    = 1'b0;
    logic          done_g0    = 1'b0;

    logic          load_ready_g1, a_tvalid_g1, b_tvalid_g1, busy_g1, frame_done_g1;
    logic [DW-1:0] a_g1, b_g1;
    logic          load_ready_g0, a_tvalid_g0, b_tvalid_g0, busy_g0, frame_done_g0;
    logic [DW-1:0] a_g0, b_g0;

    logic [DW-1:0] words [20];
    int            mac   [4];
    int            checks = 0;
    int            passed = 0;

    always #5 clk = ~clk;

    matrix_operand_feeder #(.DATA_W(DW), .N(4), .GAP(1)) dut_g1 (
        .clk             (clk),
        .reset           (reset),
        .clear           (clear),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .load_ready      (load_ready_g1),
        .a               (a_g1),
        .b               (b_g1),
        .a_tvalid        (a_tvalid_g1),
        .b_tvalid        (b_tvalid_g1),
        .done_matrixmult (done_g1),
        .busy            (busy_g1),
        .frame_done      (frame_done_g1)
    );

    matrix_operand_feeder #(.DATA_W(DW), .N(4), .GAP(0)) dut_g0 (
        .clk             (clk),
        .reset           (reset),
        .clear           (clear),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .load_ready      (load_ready_g0),
        .a               (a_g0),
        .b               (b_g0),
        .a_tvalid        (a_tvalid_g0),
        .b_tvalid        (b_tvalid_g0),
        .done_matrixmult (done_g0),
        .busy            (busy_g0),
        .frame_done      (frame_done_g0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_idle_outputs(input string tag, input logic ready_exp);
        chk({tag, "_a_g1"}, a_g1, 0);
        chk({tag, "_b_g1"}, b_g1, 0);
        chk({tag, "_tvalid_g1"}, {a_tvalid_g1, b_tvalid_g1}, 0);
        chk({tag, "_busy_g1"}, busy_g1, 0);
        chk({tag, "_frame_done_g1"}, frame_done_g1, 0);
        chk({tag, "_load_ready_g1"}, load_ready_g1, ready_exp);
        chk({tag, "_a_g0"}, a_g0, 0);
        chk({tag, "_tvalid_g0"}, {a_tvalid_g0, b_tvalid_g0}, 0);
        chk({tag, "_busy_g0"}, busy_g0, 0);
        chk({tag, "_frame_done_g0"}, frame_done_g0, 0);
        chk({tag, "_load_ready_g0"}, load_ready_g0, ready_exp);
    endtask

    task automatic load_frame(input bit bubbles);
        for (int i = 0; i < 20; i++) begin
            if (bubbles) begin
                int nb;
                nb = $urandom_range(0, 2);
                for (int k = 0; k < nb; k++) begin
                    load_valid = 1'b0;
                    load_data  = 32'hBAD0_0000 + k;
                    @(negedge clk);
                end
            end
            chk("load_ready_g1", load_ready_g1, 1);
            chk("load_ready_g0", load_ready_g0, 1);
            load_valid = 1'b1;
            load_data  = words[i];
            @(negedge clk);
            chk("load_busy_g1", busy_g1, 1);
            chk("load_frame_done_g1", frame_done_g1, 0);
            if (i < 19) chk("load_tvalid_g1", a_tvalid_g1, 0);
        end
        load_valid = 1'b0;
    endtask

    // Starts at cycle T+1; ends at the cycle both feeders sit in WAIT_DONE.
    task automatic run_issue(input bit hold_done);
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        for (int j = 0; j < 32; j++) begin
            int k1;
            k1 = j / 2;
            chk("g1_a_tvalid", a_tvalid_g1, (j % 2 == 0));
            chk("g1_b_tvalid", b_tvalid_g1, (j % 2 == 0));
            chk("g1_a", a_g1, words[k1]);
            chk("g1_b", b_g1, words[16 + k1 % 4]);
            chk("g1_busy", busy_g1, 1);
            chk("g1_frame_done", frame_done_g1, 0);
            chk("g1_load_ready", load_ready_g1, 0);
            if (a_tvalid_g1) mac[k1 / 4] += int'(a_g1 * b_g1);
            if (j < 16) begin
                chk("g0_a_tvalid", a_tvalid_g0, 1);
                chk("g0_b_tvalid", b_tvalid_g0, 1);
                chk("g0_a", a_g0, words[j]);
                chk("g0_b", b_g0, words[16 + j % 4]);
            end else begin
                chk("g0_wait_tvalid", a_tvalid_g0, 0);
            end
            chk("g0_busy", busy_g0, 1);
            chk("g0_frame_done", frame_done_g0, 0);
            done_g1 = hold_done && (j < 30);
            if (j == 31) load_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic finish_frame();
        chk("wait_busy_g1", busy_g1, 1);
        chk("wait_tvalid_g1", a_tvalid_g1, 0);
        chk("wait_frame_done_g1", frame_done_g1, 0);
        done_g1 = 1'b1;
        done_g0 = 1'b1;
        @(negedge clk);
        done_g1 = 1'b0;
        done_g0 = 1'b0;
        chk("done_frame_done_g1", frame_done_g1, 1);
        chk("done_busy_g1", busy_g1, 0);
        chk("done_load_ready_g1", load_ready_g1, 0);
        chk("done_frame_done_g0", frame_done_g0, 1);
        chk("done_busy_g0", busy_g0, 0);
        @(negedge clk);
        chk("post_frame_done_g1", frame_done_g1, 0);
        chk("post_load_ready_g1", load_ready_g1, 1);
        chk("post_frame_done_g0", frame_done_g0, 0);
    endtask

    initial begin
        logic [DW-1:0] m_rows [16] = '{1, 1, 2, 3, 5, 6, 7, 3, 1, 2, 3, 2, 4, 5, 3, 5};
        logic [DW-1:0] v_vec  [4]  = '{2, 5, 3, 1};
        for (int i = 0; i < 16; i++) words[i] = m_rows[i];
        for (int i = 0; i < 4; i++) words[16 + i] = v_vec[i];
        for (int i = 0; i < 4; i++) mac[i] = 0;

        // reset state, then load_ready rises at the first edge after release
        #12;
        chk_idle_outputs("in_reset", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        chk("release_load_ready_g1", load_ready_g1, 0);
        @(negedge clk);
        chk("first_edge_load_ready_g1", load_ready_g1, 1);
        chk("first_edge_load_ready_g0", load_ready_g0, 1);

        // frame 1: done held high through load and issue must be ignored
        done_g1 = 1'b1;
        load_frame(1'b0);
        run_issue(1'b1);
        finish_frame();
        chk("mac_row0", mac[0], 16);
        chk("mac_row1", mac[1], 64);
        chk("mac_row2", mac[2], 23);
        chk("mac_row3", mac[3], 47);

        // frame 2: new data with random load bubbles
        for (int i = 0; i < 20; i++) words[i] = 32'hA000_0000 + i * 32'h0101;
        load_frame(1'b1);
        run_issue(1'b0);
        finish_frame();

        // frame 3: async reset at pair 7 of the GAP=1 feeder
        for (int i = 0; i < 20; i++) words[i] = $urandom;
        load_frame(1'b0);
        for (int j = 0; j < 14; j++) @(negedge clk);
        chk("pair7_tvalid_g1", a_tvalid_g1, 1);
        chk("pair7_a_g1", a_g1, words[7]);
        chk("pair7_b_g1", b_g1, words[19]);
        #1;
        reset = 1'b0;
        #1;
        chk_idle_outputs("async_reset", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("after_reset", 1'b1);

        // frame 4: clear in WAIT_DONE, together with done, wins
        for (int i = 0; i < 20; i++) words[i] = $urandom;
        load_frame(1'b0);
        run_issue(1'b0);
        chk("pre_clear_busy_g1", busy_g1, 1);
        chk("pre_clear_busy_g0", busy_g0, 1);
        clear   = 1'b1;
        done_g1 = 1'b1;
        done_g0 = 1'b1;
        @(negedge clk);
        clear   = 1'b0;
        done_g1 = 1'b0;
        done_g0 = 1'b0;
        chk_idle_outputs("after_clear", 1'b1);
        @(negedge clk);
        chk("clear_no_frame_done_g1", frame_done_g1, 0);
        chk("clear_no_frame_done_g0", frame_done_g0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/matrix_operand_feeder.md
MATRIX_OPERAND_FEEDER -- requirements
Module: matrix_operand_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand word width.
REQ-002 SHALL have parameter N, default 4, matrix dimension (N x N matrix, N-element pixel vector).
REQ-003 SHALL have parameter GAP, default 1, idle cycles between consecutive operand-valid cycles (range 0..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous abort of the current frame.
REQ-007 SHALL have port load_data  input  DATA_W  operand word being loaded.
REQ-008 SHALL have port load_valid  input  1  load_data is valid.
REQ-009 SHALL have port load_ready  output  1  block accepts a load word this cycle.
REQ-010 SHALL have port a  output  DATA_W  matrix element to the multiplier.
REQ-011 SHALL have port b  output  DATA_W  pixel element to the multiplier.
REQ-012 SHALL have port a_tvalid  output  1  a is valid.
REQ-013 SHALL have port b_tvalid  output  1  b is valid; always equal to a_tvalid.
REQ-014 SHALL have port done_matrixmult  input  1  completion pulse from the downstream multiplier.
REQ-015 SHALL have port busy  output  1  frame loading or issuing in progress.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse when the frame completes.

Function
REQ-017 SHALL implement states IDLE, LOAD, ISSUE, GAP_WAIT, WAIT_DONE, DONE.
REQ-018 SHALL, in IDLE and LOAD, drive load_ready=1; a word transfers when load_valid && load_ready.
REQ-019 SHALL store words in order: words 0..N*N-1 = matrix row-major M[r][c]; words N*N..N*N+N-1 = pixel vector V[c].
REQ-020 SHALL move IDLE->LOAD on the first accepted word and LOAD->ISSUE on the cycle after word N*N+N-1 is accepted.
REQ-021 SHALL drive load_ready=0 in ISSUE, GAP_WAIT, WAIT_DONE and DONE; load_valid is ignored there.
REQ-022 SHALL, for pair k = 0..N*N-1, drive a=M[k/N][k%N] and b=V[k%N] with a_tvalid=b_tvalid=1 for exactly one cycle (ISSUE).
REQ-023 SHALL hold a and b stable from the ISSUE cycle of pair k until the ISSUE cycle of pair k+1.
REQ-024 SHALL follow each ISSUE with exactly GAP cycles in GAP_WAIT with tvalid=0; GAP=0 gives back-to-back valid cycles.
REQ-025 SHALL issue pair k at cycle T+1+k*(GAP+1), where T is the cycle of the last load transfer.
REQ-026 SHALL enter WAIT_DONE after the GAP_WAIT of pair N*N-1, or directly after its ISSUE when GAP=0.
REQ-027 SHALL ignore done_matrixmult in every state except WAIT_DONE.
REQ-028 SHALL, on done_matrixmult in WAIT_DONE, go to DONE, pulse frame_done for one cycle, then return to IDLE.
REQ-029 SHALL drive busy=1 in LOAD, ISSUE, GAP_WAIT and WAIT_DONE; busy=0 in IDLE and DONE.
REQ-030 SHALL, on clear=1 in any state, go to IDLE next cycle, zero the counters and tvalid, and assert no frame_done; clear has priority over every other event in that cycle.
REQ-031 SHALL use a load counter of width clog2(N*N+N) and a pair counter of width clog2(N*N), both saturating at their terminal value with no wrap.
REQ-032 SHALL pass operand bits through unmodified (no arithmetic on data).

Reset
REQ-033 SHALL, while reset=0, asynchronously force state IDLE, counters 0, a=0, b=0, a_tvalid=b_tvalid=0, busy=0, frame_done=0, load_ready=0.
REQ-034 SHALL drive load_ready=1 from the first clock edge after reset deassertion.
REQ-035 SHALL leave operand storage contents unspecified after reset; every frame reloads all N*N+N words.

Structure
REQ-036 SHALL place DATA_W, N, LOAD_WORDS=N*N+N and the state enum typedef in shared package gpu2_mm_pkg.
REQ-037 SHALL implement storage as sub-module operand_regfile: N*N+N words, 1 write port, 2 combinational read ports.

Verification
REQ-038 SHALL load M rows {1,1,2,3},{5,6,7,3},{1,2,3,2},{4,5,3,5} and V={2,5,3,1} with GAP=1 -> 16 valid pulses every 2nd cycle; (a,b) sequence (1,2),(1,5),(2,3),(3,1),(5,2)...(5,1); a reference MAC gives 16,64,23,47.
REQ-039 SHALL hold done_matrixmult high during LOAD and ISSUE -> ignored, no frame_done; then pulse it in WAIT_DONE -> frame_done pulses one cycle later and busy falls.
REQ-040 SHALL run GAP=0 -> 16 consecutive tvalid cycles starting at T+1.
REQ-041 SHALL deassert load_valid randomly during LOAD -> storage and issue order unchanged; first ISSUE at last transfer +1.
REQ-042 SHALL assert reset=0 asynchronously mid-ISSUE (pair 7), then assert clear mid-WAIT_DONE -> outputs match REQ-033 immediately; state IDLE next cycle after clear; no frame_done.
